// File: rtl/riscv_pkg.sv
// Shared architectural constants and the writeback entry layout used by the
// load-result buffer and the register-file writeback stage.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  typedef struct packed {
    reg_addr_t rd;
    xlen_t     value;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_LOAD = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding load results until the writeback port is free.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A full buffer refuses pushes even when it also pops this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Single register-file write port shared by the ALU and buffered load results,
// with ALU priority bounded by a starvation limit and a pending-load scoreboard.
module regfile_writeback
  import riscv_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  SYS_clk,
  input  logic                  SYS_reset,
  input  logic                  WB_alu_valid,
  output logic                  WB_alu_ready,
  input  logic [REG_ADDR_W-1:0] WB_alu_rd,
  input  logic [XLEN-1:0]       WB_alu_value,
  input  logic                  LSU_valid,
  output logic                  LSU_ready,
  input  logic [REG_ADDR_W-1:0] LSU_rd,
  input  logic [XLEN-1:0]       LSU_value,
  input  logic                  ISS_issue_valid,
  input  logic [REG_ADDR_W-1:0] ISS_issue_rd,
  output logic [NUM_REGS-1:0]   SB_busy,
  output logic [REG_ADDR_W-1:0] REG_write_address,
  output logic                  REG_write_enable,
  output logic [XLEN-1:0]       REG_write_value
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  wb_entry_t        push_entry;
  wb_entry_t        head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             push, pop, alu_win;

  logic [STV_W-1:0]      starve_q, starve_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]       wr_val_q, wr_val_d;

  wb_src_e               src;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_val;

  assign push_entry = '{rd: LSU_rd, value: LSU_value};

  wb_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_load_fifo (
    .clk_i       (SYS_clk),
    .rst_i       (SYS_reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign LSU_ready    = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign WB_alu_ready = !((starve_q == STV_W'(STARVE_LIMIT)) && !fifo_empty);

  // Reset blocks every transfer so nothing buffered or issued survives it.
  assign alu_win = !SYS_reset && WB_alu_valid && WB_alu_ready;
  assign pop     = !SYS_reset && !alu_win && !fifo_empty;
  assign push    = !SYS_reset && LSU_valid && !fifo_full;

  always_comb begin
    src     = WB_SRC_NONE;
    sel_rd  = '0;
    sel_val = '0;
    if (alu_win) begin
      src     = WB_SRC_ALU;
      sel_rd  = WB_alu_rd;
      sel_val = WB_alu_value;
    end else if (pop) begin
      src     = WB_SRC_LOAD;
      sel_rd  = head.rd;
      sel_val = head.value;
    end
  end

  // x0 writes still consume their slot; only the strobe is suppressed.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_val_d  = wr_val_q;
    if (src != WB_SRC_NONE) begin
      wr_en_d   = (sel_rd != '0);
      wr_addr_d = sel_rd;
      wr_val_d  = sel_val;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (alu_win && (starve_q != STV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  // Clear first, then set, so a same-cycle re-issue of the popped rd stays busy.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head.rd] = 1'b0;
    if (ISS_issue_valid) busy_d[ISS_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      starve_q  <= '0;
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_val_q  <= '0;
    end else begin
      starve_q  <= starve_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_val_q  <= wr_val_d;
    end
  end

  assign SB_busy           = busy_q;
  assign REG_write_enable  = wr_en_q;
  assign REG_write_address = wr_addr_q;
  assign REG_write_value   = wr_val_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench: directed scenarios plus a randomized run, all compared
// against a queue-based transaction model of the writeback port.
module tb_regfile_writeback;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        SYS_clk = 1'b0;
  logic        SYS_reset;
  logic        WB_alu_valid;
  logic        WB_alu_ready;
  logic [4:0]  WB_alu_rd;
  logic [31:0] WB_alu_value;
  logic        LSU_valid;
  logic        LSU_ready;
  logic [4:0]  LSU_rd;
  logic [31:0] LSU_value;
  logic        ISS_issue_valid;
  logic [4:0]  ISS_issue_rd;
  logic [31:0] SB_busy;
  logic [4:0]  REG_write_address;
  logic        REG_write_enable;
  logic [31:0] REG_write_value;

  always #5 SYS_clk = ~SYS_clk;

  regfile_writeback #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .SYS_clk           (SYS_clk),
    .SYS_reset         (SYS_reset),
    .WB_alu_valid      (WB_alu_valid),
    .WB_alu_ready      (WB_alu_ready),
    .WB_alu_rd         (WB_alu_rd),
    .WB_alu_value      (WB_alu_value),
    .LSU_valid         (LSU_valid),
    .LSU_ready         (LSU_ready),
    .LSU_rd            (LSU_rd),
    .LSU_value         (LSU_value),
    .ISS_issue_valid   (ISS_issue_valid),
    .ISS_issue_rd      (ISS_issue_rd),
    .SB_busy           (SB_busy),
    .REG_write_address (REG_write_address),
    .REG_write_enable  (REG_write_enable),
    .REG_write_value   (REG_write_value)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: pending loads in order, plus expected port state.
  logic [4:0]  q_rd[$];
  logic [31:0] q_val[$];
  int          m_starve;
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wv;

  function automatic logic m_alu_ready();
    return !((m_starve == LIMIT) && (q_rd.size() > 0));
  endfunction

  function automatic logic m_lsu_ready();
    return q_rd.size() < DEPTH;
  endfunction

  task automatic idle_inputs();
    WB_alu_valid = 0; WB_alu_rd = 0; WB_alu_value = 0;
    LSU_valid = 0; LSU_rd = 0; LSU_value = 0;
    ISS_issue_valid = 0; ISS_issue_rd = 0;
  endtask

  task automatic settle();
    @(negedge SYS_clk);
  endtask

  // Apply this cycle's inputs to the model, then move to just after the edge.
  task automatic advance();
    logic       win, popped, push_ok;
    logic [4:0] prd;
    int         pre_size;
    if (SYS_reset) begin
      q_rd.delete(); q_val.delete();
      m_starve = 0; m_busy = 0; m_we = 0; m_wa = 0; m_wv = 0;
    end else begin
      pre_size = q_rd.size();
      win      = WB_alu_valid && m_alu_ready();
      push_ok  = LSU_valid && m_lsu_ready();
      popped   = 0;
      prd      = 0;
      if (win) begin
        m_we = (WB_alu_rd != 0); m_wa = WB_alu_rd; m_wv = WB_alu_value;
      end else if (pre_size > 0) begin
        prd = q_rd.pop_front();
        m_wv = q_val.pop_front();
        m_wa = prd; m_we = (prd != 0); popped = 1;
      end else begin
        m_we = 0;
      end
      if (pre_size == 0 || popped) m_starve = 0;
      else if (win && m_starve < LIMIT) m_starve++;
      if (push_ok) begin q_rd.push_back(LSU_rd); q_val.push_back(LSU_value); end
      if (popped) m_busy[prd] = 1'b0;
      if (ISS_issue_valid) m_busy[ISS_issue_rd] = 1'b1;
      m_busy[0] = 1'b0;
    end
    @(posedge SYS_clk);
    #1;
  endtask

  task automatic test_reset();
    SYS_reset = 1; idle_inputs();
    advance(); advance();
    settle();
    n_tests++;
    if (REG_write_enable !== 1'b0 || REG_write_address !== 5'd0 || REG_write_value !== 32'd0) begin
      n_fail++; $display("FAIL reset_write: got en=%b addr=%0d val=%h expected 0/0/0", REG_write_enable, REG_write_address, REG_write_value);
    end
    n_tests++;
    if (SB_busy !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", SB_busy); end
    n_tests++;
    if (LSU_ready !== 1'b1 || WB_alu_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got lsu=%b alu=%b expected 1/1", LSU_ready, WB_alu_ready);
    end
    advance();
    SYS_reset = 0;
  endtask

  task automatic test_alu();
    WB_alu_valid = 1; WB_alu_rd = 5; WB_alu_value = 32'h0000_00AA;
    settle();
    n_tests++;
    if (WB_alu_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready: got %b expected 1", WB_alu_ready); end
    advance();
    idle_inputs();
    settle();
    n_tests++;
    if (REG_write_enable !== 1'b1 || REG_write_address !== 5'd5 || REG_write_value !== 32'hAA) begin
      n_fail++; $display("FAIL alu_write: got en=%b addr=%0d val=%h expected 1/5/aa", REG_write_enable, REG_write_address, REG_write_value);
    end
    advance();
    settle();
    n_tests++;
    if (REG_write_enable !== 1'b0) begin n_fail++; $display("FAIL alu_single_cycle: got en=%b expected 0", REG_write_enable); end
    WB_alu_valid = 1; WB_alu_rd = 0; WB_alu_value = 32'h55;
    advance();
    idle_inputs();
    settle();
    n_tests++;
    if (REG_write_enable !== 1'b0) begin n_fail++; $display("FAIL alu_rd0: got en=%b expected 0", REG_write_enable); end
    advance();
  endtask

  task automatic test_load();
    ISS_issue_valid = 1; ISS_issue_rd = 7;
    settle(); advance();
    idle_inputs();
    LSU_valid = 1; LSU_rd = 7; LSU_value = 32'hDEAD_BEEF;
    settle();
    n_tests++;
    if (SB_busy[7] !== 1'b1 || LSU_ready !== 1'b1) begin
      n_fail++; $display("FAIL load_issue: got busy7=%b lsu_ready=%b expected 1/1", SB_busy[7], LSU_ready);
    end
    advance();
    idle_inputs();
    settle();
    n_tests++;
    if (SB_busy[7] !== 1'b1 || REG_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL load_pending: got busy7=%b en=%b expected 1/0", SB_busy[7], REG_write_enable);
    end
    advance();
    settle();
    n_tests++;
    if (REG_write_enable !== 1'b1 || REG_write_address !== 5'd7 || REG_write_value !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL load_write: got en=%b addr=%0d val=%h expected 1/7/deadbeef", REG_write_enable, REG_write_address, REG_write_value);
    end
    n_tests++;
    if (SB_busy[7] !== 1'b0) begin n_fail++; $display("FAIL load_busy_clear: got %b expected 0", SB_busy[7]); end
    advance();
  endtask

  task automatic test_full();
    int ld_idx = 0;
    int k = 0;
    int third_cyc = -1;
    logic ld_acc, alu_acc;
    for (int cyc = 0; cyc < 20; cyc++) begin
      WB_alu_valid = 1; WB_alu_rd = 9; WB_alu_value = 32'h1000 + k;
      LSU_valid = (ld_idx < 3); LSU_rd = 5'(10 + ld_idx); LSU_value = 32'hC0DE_0000 + ld_idx;
      settle();
      n_tests++;
      if (LSU_ready !== m_lsu_ready() || WB_alu_ready !== m_alu_ready()) begin
        n_fail++; $display("FAIL full_ready c%0d: got lsu=%b alu=%b expected %b/%b", cyc, LSU_ready, WB_alu_ready, m_lsu_ready(), m_alu_ready());
      end
      n_tests++;
      if (REG_write_enable !== m_we || (m_we && (REG_write_address !== m_wa || REG_write_value !== m_wv))) begin
        n_fail++; $display("FAIL full_write c%0d: got en=%b addr=%0d val=%h expected %b/%0d/%h", cyc, REG_write_enable, REG_write_address, REG_write_value, m_we, m_wa, m_wv);
      end
      if (cyc == 2) begin
        n_tests++;
        if (LSU_ready !== 1'b0) begin n_fail++; $display("FAIL full_not_ready: got %b expected 0", LSU_ready); end
      end
      ld_acc  = LSU_valid && m_lsu_ready();
      alu_acc = m_alu_ready();
      if (ld_acc && ld_idx == 2) third_cyc = cyc;
      advance();
      if (ld_acc) ld_idx++;
      if (alu_acc) k++;
    end
    n_tests++;
    if (third_cyc != 6) begin n_fail++; $display("FAIL full_third_accept: got cycle %0d expected 6", third_cyc); end
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      settle();
      n_tests++;
      if (REG_write_enable !== m_we || (m_we && (REG_write_address !== m_wa || REG_write_value !== m_wv))) begin
        n_fail++; $display("FAIL full_drain: got en=%b addr=%0d val=%h expected %b/%0d/%h", REG_write_enable, REG_write_address, REG_write_value, m_we, m_wa, m_wv);
      end
      advance();
    end
  endtask

  task automatic test_starve();
    int k = 0;
    logic acc;
    for (int cyc = 0; cyc < 8; cyc++) begin
      WB_alu_valid = 1; WB_alu_rd = 20; WB_alu_value = 32'h2000 + k;
      LSU_valid = (cyc == 0); LSU_rd = 12; LSU_value = 32'h1234_5678;
      settle();
      if (cyc >= 1 && cyc <= 4) begin
        n_tests++;
        if (WB_alu_ready !== 1'b1) begin n_fail++; $display("FAIL starve_ready c%0d: got %b expected 1", cyc, WB_alu_ready); end
      end
      if (cyc == 5) begin
        n_tests++;
        if (WB_alu_ready !== 1'b0) begin n_fail++; $display("FAIL starve_stall: got %b expected 0", WB_alu_ready); end
      end
      if (cyc == 6) begin
        n_tests++;
        if (REG_write_enable !== 1'b1 || REG_write_address !== 5'd12 || REG_write_value !== 32'h1234_5678 || WB_alu_ready !== 1'b1) begin
          n_fail++; $display("FAIL starve_load: got en=%b addr=%0d val=%h alu_ready=%b expected 1/12/12345678/1", REG_write_enable, REG_write_address, REG_write_value, WB_alu_ready);
        end
      end
      if (cyc == 7) begin
        n_tests++;
        if (REG_write_enable !== 1'b1 || REG_write_address !== 5'd20) begin
          n_fail++; $display("FAIL starve_resume: got en=%b addr=%0d expected 1/20", REG_write_enable, REG_write_address);
        end
      end
      acc = m_alu_ready();
      advance();
      if (acc) k++;
    end
    idle_inputs();
    advance();
  endtask

  task automatic test_same_cycle();
    idle_inputs();
    ISS_issue_valid = 1; ISS_issue_rd = 3;
    advance();
    idle_inputs();
    LSU_valid = 1; LSU_rd = 3; LSU_value = 32'h33;
    advance();
    idle_inputs();
    ISS_issue_valid = 1; ISS_issue_rd = 3;
    advance();
    idle_inputs();
    settle();
    n_tests++;
    if (SB_busy[3] !== 1'b1 || REG_write_enable !== 1'b1 || REG_write_address !== 5'd3) begin
      n_fail++; $display("FAIL same_cycle: got busy3=%b en=%b addr=%0d expected 1/1/3", SB_busy[3], REG_write_enable, REG_write_address);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    ISS_issue_valid = 1; ISS_issue_rd = 14;
    advance();
    for (int i = 0; i < 2; i++) begin
      idle_inputs();
      WB_alu_valid = 1; WB_alu_rd = 21; WB_alu_value = 32'h99;
      LSU_valid = 1; LSU_rd = 5'(14 + i); LSU_value = 32'hAB00 + i;
      advance();
    end
    idle_inputs();
    settle();
    n_tests++;
    if (LSU_ready !== 1'b0) begin n_fail++; $display("FAIL resetmid_full: got %b expected 0", LSU_ready); end
    SYS_reset = 1;
    advance();
    SYS_reset = 0;
    settle();
    n_tests++;
    if (REG_write_enable !== 1'b0 || LSU_ready !== 1'b1 || SB_busy !== 32'd0) begin
      n_fail++; $display("FAIL resetmid_state: got en=%b lsu=%b busy=%h expected 0/1/0", REG_write_enable, LSU_ready, SB_busy);
    end
    for (int i = 0; i < 4; i++) begin
      advance();
      settle();
      n_tests++;
      if (REG_write_enable !== 1'b0) begin n_fail++; $display("FAIL resetmid_nowrite %0d: got en=%b expected 0", i, REG_write_enable); end
    end
    advance();
  endtask

  task automatic test_random();
    logic alu_pend = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      SYS_reset = ($urandom_range(79) == 0);
      if (!alu_pend) begin
        WB_alu_valid = $urandom_range(1);
        WB_alu_rd    = 5'($urandom_range(31));
        WB_alu_value = $urandom;
      end
      LSU_valid       = ($urandom_range(2) == 0);
      LSU_rd          = 5'($urandom_range(31));
      LSU_value       = $urandom;
      ISS_issue_valid = ($urandom_range(2) == 0);
      ISS_issue_rd    = 5'($urandom_range(31));
      settle();
      n_tests++;
      if (WB_alu_ready !== m_alu_ready() || LSU_ready !== m_lsu_ready()) begin
        n_fail++; $display("FAIL rand_ready c%0d: got alu=%b lsu=%b expected %b/%b", cyc, WB_alu_ready, LSU_ready, m_alu_ready(), m_lsu_ready());
      end
      n_tests++;
      if (REG_write_enable !== m_we || (m_we && (REG_write_address !== m_wa || REG_write_value !== m_wv))) begin
        n_fail++; $display("FAIL rand_write c%0d: got en=%b addr=%0d val=%h expected %b/%0d/%h", cyc, REG_write_enable, REG_write_address, REG_write_value, m_we, m_wa, m_wv);
      end
      n_tests++;
      if (SB_busy !== m_busy) begin n_fail++; $display("FAIL rand_busy c%0d: got %h expected %h", cyc, SB_busy, m_busy); end
      alu_pend = WB_alu_valid && !m_alu_ready() && !SYS_reset;
      advance();
    end
    SYS_reset = 0;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    SYS_reset = 1;
    idle_inputs();
    q_rd.delete(); q_val.delete();
    m_starve = 0; m_busy = 0; m_we = 0; m_wa = 0; m_wv = 0;
    @(posedge SYS_clk); #1;
    test_reset();
    test_alu();
    test_load();
    test_full();
    test_starve();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
